// File: rtl/ui_pkg.sv
// Shared UI definitions: BCD nibble type, converter FSM encoding and display defaults.
package ui_pkg;
    localparam int BCD_W            = 4;
    localparam int DIGITS_DEF       = 5;
    localparam int BLINK_FRAMES_DEF = 30;

    typedef logic [BCD_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SHIFT       = 2'd1,
        COMMIT_WAIT = 2'd2
    } conv_state_t;
endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift the binary MSB in.
module bin2bcd_step
    import ui_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [DIGITS*BCD_W-1:0] bcd_in,
    input  logic                    bin_msb,
    output logic [DIGITS*BCD_W-1:0] bcd_out
);
    logic [DIGITS*BCD_W-1:0] adj;

    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        nibble_t nib;
        assign nib = bcd_in[i*BCD_W +: BCD_W];
        // A nibble here never exceeds 9 before adjust, so the 4-bit sum cannot wrap.
        assign adj[i*BCD_W +: BCD_W] = (nib >= nibble_t'(5)) ? nibble_t'(nib + nibble_t'(3)) : nib;
    end

    assign bcd_out = (adj << 1) | (DIGITS*BCD_W)'(bin_msb);
endmodule

// File: rtl/score_display_ctrl.sv
// Score readout sequencer: multi-cycle binary-to-BCD conversion committed on frame
// boundaries, plus the frame-timed game-over blink.
module score_display_ctrl
    import ui_pkg::*;
#(
    parameter int SCORE_W      = 16,
    parameter int DIGITS       = DIGITS_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    game_over,
    input  logic                    frame_start,
    output logic [DIGITS*BCD_W-1:0] bcd_digits,
    output logic [DIGITS-1:0]       blank_mask,
    output logic                    digits_updated,
    output logic                    busy,
    output logic                    text_visible
);
    localparam int BCD_BITS = DIGITS*BCD_W;
    localparam int CNT_W    = $clog2(SCORE_W + 1);
    localparam int BLK_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [DIGITS-1:0] MASK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    conv_state_t          state, state_nxt;
    logic [SCORE_W-1:0]   shift_reg;
    logic [SCORE_W-1:0]   last_score;
    logic [BCD_BITS-1:0]  acc;
    logic [BCD_BITS-1:0]  step_out;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIGITS-1:0]    pend_mask;
    logic                 hi_zero;
    logic                 score_diff;
    logic                 last_bit;
    logic [BLK_W-1:0]     blink_cnt;
    logic                 blink_phase;

    bin2bcd_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in  (acc),
        .bin_msb (shift_reg[SCORE_W-1]),
        .bcd_out (step_out)
    );

    assign score_diff = (score != last_score);
    assign last_bit   = (bit_cnt == CNT_W'(SCORE_W - 1));
    assign busy       = (state != IDLE);

    // Leading-zero blanking scans from the top digit; the units digit always shows.
    always_comb begin
        pend_mask = '0;
        hi_zero   = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            hi_zero      = hi_zero & (acc[i*BCD_W +: BCD_W] == '0);
            pend_mask[i] = hi_zero;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (score_diff)  state_nxt = SHIFT;
            SHIFT:       if (last_bit)    state_nxt = COMMIT_WAIT;
            COMMIT_WAIT: if (frame_start) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg      <= '0;
            last_score     <= '0;
            acc            <= '0;
            bit_cnt        <= '0;
            bcd_digits     <= '0;
            blank_mask     <= MASK_RST;
            digits_updated <= 1'b0;
        end else begin
            digits_updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (score_diff) begin
                        shift_reg  <= score;
                        last_score <= score;
                        acc        <= '0;
                        bit_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    acc       <= step_out;
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                COMMIT_WAIT: begin
                    if (frame_start) begin
                        bcd_digits     <= acc;
                        blank_mask     <= pend_mask;
                        digits_updated <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter and phase stay parked while game_over is low, so a new game-over starts visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
            text_visible <= 1'b1;
        end else begin
            text_visible <= ~game_over | blink_phase;
            if (!game_over) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (frame_start) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: conversion, frame-aligned commit, blink and reset.
module tb_score_display_ctrl;
    localparam int SCORE_W = 16;
    localparam int DIGITS  = 5;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [SCORE_W-1:0]  score;
    logic                game_over;
    logic                frame_start;
    logic [DIGITS*4-1:0] bcd_digits;
    logic [DIGITS-1:0]   blank_mask;
    logic                digits_updated;
    logic                busy;
    logic                text_visible;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int upd_base;
    logic exp_vis [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    score_display_ctrl #(.SCORE_W(SCORE_W), .DIGITS(DIGITS), .BLINK_FRAMES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .score          (score),
        .game_over      (game_over),
        .frame_start    (frame_start),
        .bcd_digits     (bcd_digits),
        .blank_mask     (blank_mask),
        .digits_updated (digits_updated),
        .busy           (busy),
        .text_visible   (text_visible)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (digits_updated === 1'b1) upd_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge: frame_start high for exactly one posedge.
    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; score = '0; game_over = 1'b0; frame_start = 1'b0;
        tick(2);
        reset_n = 1'b1;

        // 1: reset state, score 0 never converts
        check("rst_digits", 32'(bcd_digits), 32'h0);
        check("rst_mask", 32'(blank_mask), 32'b11110);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_vis", 32'(text_visible), 32'h1);
        upd_base = upd_cnt;
        repeat (3) begin tick(3); pulse_frame(); end
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_upd", 32'(upd_cnt - upd_base), 32'h0);

        // 2: 1234
        score = 16'd1234;
        tick(1);
        check("t2_busy_start", 32'(busy), 32'h1);
        tick(19);
        check("t2_busy_wait", 32'(busy), 32'h1);
        check("t2_no_commit", 32'(bcd_digits), 32'h0);
        upd_base = upd_cnt;
        pulse_frame();
        check("t2_digits", 32'(bcd_digits), 32'h01234);
        check("t2_mask", 32'(blank_mask), 32'b10000);
        check("t2_pulse", 32'(digits_updated), 32'h1);
        tick(1);
        check("t2_pulse_end", 32'(digits_updated), 32'h0);
        check("t2_busy_end", 32'(busy), 32'h0);
        check("t2_upd_cnt", 32'(upd_cnt - upd_base), 32'h1);

        // 3: 65535, frames in SHIFT ignored including the final SHIFT cycle
        score = 16'hFFFF;
        tick(5);
        pulse_frame();
        check("t3_early_frame", 32'(bcd_digits), 32'h01234);
        tick(10);
        pulse_frame();
        check("t3_last_shift_frame", 32'(bcd_digits), 32'h01234);
        check("t3_last_shift_busy", 32'(busy), 32'h1);
        pulse_frame();
        check("t3_digits", 32'(bcd_digits), 32'h65535);
        check("t3_mask", 32'(blank_mask), 32'h0);
        check("t3_pulse", 32'(digits_updated), 32'h1);

        // 4: change during SHIFT commits stale value, then reconverts
        tick(1);
        upd_base = upd_cnt;
        score = 16'd10;
        tick(5);
        score = 16'd20;
        tick(20);
        pulse_frame();
        check("t4_stale", 32'(bcd_digits), 32'h00010);
        check("t4_stale_mask", 32'(blank_mask), 32'b11100);
        tick(1);
        check("t4_reconv_busy", 32'(busy), 32'h1);
        tick(20);
        pulse_frame();
        check("t4_new", 32'(bcd_digits), 32'h00020);
        tick(1);
        check("t4_upd_cnt", 32'(upd_cnt - upd_base), 32'h2);

        // 5: blink, two frames per half-period
        game_over = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_vis%0d", i), 32'(text_visible), 32'(exp_vis[i]));
            pulse_frame();
            tick(2);
        end
        pulse_frame(); tick(2);
        pulse_frame(); tick(2);
        check("t5_vis_hidden", 32'(text_visible), 32'h0);
        game_over = 1'b0;
        tick(1);
        check("t5_vis_release", 32'(text_visible), 32'h1);

        // 6: async reset mid-SHIFT, then reconversion of the held score
        score = 16'd999;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        check("t6_digits", 32'(bcd_digits), 32'h0);
        check("t6_mask", 32'(blank_mask), 32'b11110);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_upd", 32'(digits_updated), 32'h0);
        check("t6_vis", 32'(text_visible), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        upd_base = upd_cnt;
        tick(1);
        check("t6_restart_busy", 32'(busy), 32'h1);
        tick(19);
        pulse_frame();
        check("t6_digits_after", 32'(bcd_digits), 32'h00999);
        check("t6_mask_after", 32'(blank_mask), 32'b11000);
        tick(1);
        check("t6_upd_cnt", 32'(upd_cnt - upd_base), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
